contador_universal: RTL

//  Parametrised up/down modulo counter; next generation of the generic counter used for

---
 rtl/contador_pkg.sv | 7 +
 rtl/contador_prescaler.sv | 25 ++
 rtl/contador_universal.sv | 69 ++++++
 3 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: shared mode/direction constants for every counter user
package contador_pkg;
    localparam int   MODO_WRAP = 0;
    localparam int   MODO_SAT  = 1;
    localparam logic DIR_DESCE = 1'b0;
    localparam logic DIR_SOBE  = 1'b1;
endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler: divide-by-P enable, one tick per P cycles of conta=1
// Ports: clock, zera_as_n (async active-low reset), limpa (sync clear),
//        conta (enable in), tick (comb. enable out, high on the P-th enabled cycle)
module contador_prescaler #(
    parameter int P = 4
) (
    input  logic clock,
    input  logic zera_as_n,
    input  logic limpa,
    input  logic conta,
    output logic tick
);
    localparam int W = (P > 1) ? $clog2(P) : 1;
    localparam logic [W-1:0] TOPO = W'(P - 1);
    logic [W-1:0] cnt;
    assign tick = conta && (cnt == TOPO);
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n)
            cnt <= '0;
        else if (limpa)
            cnt <= '0;
        else if (conta)
            cnt <= (cnt == TOPO) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/contador_universal.sv
// contador_universal: up/down modulo counter with load, wrap/saturate and overflow pulse
// Ports: clock, zera_as_n (async active-low reset), zera_s (sync clear), conta (enable),
//        carrega/valor (sync load, clamped to limite), direcao (1 up, 0 down),
//        limite (run-time max), Q (value), fim (terminal count), meio (Q == limite>>1),
//        estouro (registered boundary pulse)
// Build option: CONTADOR_PRESCALER_EN inserts a divide-by-P prescaler on conta.
module contador_universal
    import contador_pkg::*;
#(
    parameter int N   = 10,
    parameter int SAT = MODO_WRAP,
    parameter int P   = 4
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic         zera_s,
    input  logic         conta,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic         direcao,
    input  logic [N-1:0] limite,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio,
    output logic         estouro
);
    logic         tick;
    logic         borda;
    logic [N-1:0] q_prox;
    if (P < 1 || P > 65536) begin : g_p_invalido
        $error("contador_universal: P must be in 1..65536");
    end
`ifdef CONTADOR_PRESCALER_EN
    contador_prescaler #(.P(P)) u_pre (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .limpa     (zera_s | carrega),
        .conta     (conta),
        .tick      (tick)
    );
`else
    assign tick = conta;
`endif
    // Q above a lowered limite counts as "at limit" going up; going down it snaps to limite
    always_comb begin
        borda  = (direcao == DIR_SOBE) ? (Q >= limite) : (Q == '0);
        q_prox = (direcao == DIR_SOBE)
               ? (borda ? ((SAT == MODO_SAT) ? limite : '0) : Q + 1'b1)
               : (borda ? ((SAT == MODO_SAT) ? '0 : limite) : (Q > limite) ? limite : Q - 1'b1);
    end
    assign fim  = borda;
    assign meio = (Q == (limite >> 1));
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            Q       <= '0;
            estouro <= 1'b0;
        end else if (zera_s) begin
            Q       <= '0;
            estouro <= 1'b0;
        end else if (carrega) begin
            Q       <= (valor > limite) ? limite : valor;
            estouro <= 1'b0;
        end else begin
            if (tick)
                Q <= q_prox;
            estouro <= tick & borda;
        end
    end
endmodule
